// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - wait-state RAM slave sharing the memory-data-register enable/ctrl bus
module ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              enable,
    input  logic [1:0]        ctrl,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       RAMio,
    output logic              ready,
    output logic              busy,
    output logic              abort
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_WAIT,
        WR_DATA,
        DONE
    } state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       mem [2**ADDR_W];

    logic rd_req;
    logic wr_req;
    logic do_write;

    assign rd_req   = enable && (ctrl == 2'b01);
    assign wr_req   = enable && (ctrl == 2'b11);
    assign do_write = (state == WR_DATA) && wr_req;

    // The bus is only ours for the single read data-phase cycle.
    assign RAMio = (state == RD_DATA) ? mem[addr_q] : 16'bz;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            addr_q <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            abort  <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        addr_q <= addr;
                        busy   <= 1'b1;
                        cnt    <= CNT_INIT;
                        if (WAIT_STATES == 0) begin
                            state <= rd_req ? RD_DATA : WR_DATA;
                            ready <= 1'b1;
                        end else begin
                            state <= rd_req ? RD_WAIT : WR_WAIT;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // A request that changes type counts as withdrawn.
                    if ((state == RD_WAIT) ? !rd_req : !wr_req) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else if (cnt == 3'd0) begin
                        state <= (state == RD_WAIT) ? RD_DATA : WR_DATA;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RD_DATA: begin
                    state <= DONE;
                    ready <= 1'b0;
                end
                WR_DATA: begin
                    ready <= 1'b0;
                    if (wr_req) begin
                        state <= DONE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end
                end
                DONE: begin
                    if (!(rd_req || wr_req)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive clr_n.
    always_ff @(posedge clk) begin
        if (clr_n && do_write) begin
            mem[addr_q] <= RAMio;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder (WAIT_STATES=2 and 0)
module tb_ram_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        enable, enable1;
    logic [1:0]  ctrl, ctrl1;
    logic [7:0]  addr, addr1;
    logic [15:0] drv, drv1;
    logic        oe, oe1;
    wire  [15:0] ramio, ramio1;
    logic        ready, busy, abort;
    logic        ready1, busy1, abort1;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign ramio  = oe  ? drv  : 16'hzzzz;
    assign ramio1 = oe1 ? drv1 : 16'hzzzz;

    ram_responder #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .clr_n(clr_n), .enable(enable), .ctrl(ctrl), .addr(addr),
        .RAMio(ramio), .ready(ready), .busy(busy), .abort(abort)
    );

    ram_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0ws (
        .clk(clk), .clr_n(clr_n), .enable(enable1), .ctrl(ctrl1), .addr(addr1),
        .RAMio(ramio1), .ready(ready1), .busy(busy1), .abort(abort1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Read data is checked whenever the DUT presents a read data phase.
    always @(negedge clk) begin
        if (clr_n && ready && enable && ctrl == 2'b01) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_rdata", {16'h0, ramio}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [15:0] d, input int hold);
        enable = 1'b1;
        ctrl   = wr ? 2'b11 : 2'b01;
        addr   = a;
        oe     = 1'b1;
        drv    = wr ? d : 16'h5A5A;
        if (wr) model[a] = d;
        else exp_q.push_back(model[a]);
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            chk("xfer_ready", {31'h0, ready}, {31'h0, c == WS + 1});
            chk("xfer_busy", {31'h0, busy}, 32'd1);
            if (!wr && c != WS + 1) chk("xfer_bus_z", {16'h0, ramio}, 32'h5A5A);
            #1;
            addr = ~a;
            if (!wr) oe = (c != WS);
            if (wr && c == WS + 2) drv = ~d;
        end
        enable = 1'b0;
        ctrl   = 2'b00;
        drv    = 16'h5A5A;
        oe     = 1'b1;
        @(negedge clk);
        chk("xfer_end_busy", {31'h0, busy}, 32'd0);
        chk("xfer_end_abort", {31'h0, abort}, 32'd0);
        chk("xfer_end_ready", {31'h0, ready}, 32'd0);
        #1;
    endtask

    task automatic rd_reset(input int at);
        enable = 1'b1;
        ctrl   = 2'b01;
        addr   = 8'h12;
        drv    = 16'h5A5A;
        oe     = 1'b1;
        if (at == WS + 1) exp_q.push_back(model[8'h12]);
        for (int c = 1; c <= at; c++) begin
            @(negedge clk);
            #1;
            oe = (c != WS);
        end
        #1;
        clr_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'h0, ready}, 32'd0);
        chk("rst_mid_busy", {31'h0, busy}, 32'd0);
        chk("rst_mid_abort", {31'h0, abort}, 32'd0);
        chk("rst_mid_bus_z", {16'h0, ramio}, 32'h5A5A);
        enable = 1'b0;
        ctrl   = 2'b00;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; enable = 1'b0; ctrl = 2'b00; addr = 8'h00; drv = 16'h5A5A; oe = 1'b1;
        enable1 = 1'b0; ctrl1 = 2'b00; addr1 = 8'h00; drv1 = 16'h5A5A; oe1 = 1'b1;
        #2;
        chk("rst_ready", {31'h0, ready}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_abort", {31'h0, abort}, 32'd0);
        chk("rst_bus_z", {16'h0, ramio}, 32'h5A5A);
        chk("rst_ready_ws0", {31'h0, ready1}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        clr_n = 1'b1;

        xfer(1'b1, 8'h12, 16'hBEEF, WS + 2);
        xfer(1'b0, 8'h12, 16'h0000, WS + 2);

        // write withdrawn after one wait cycle
        xfer(1'b1, 8'h20, 16'h1234, WS + 2);
        enable = 1'b1; ctrl = 2'b11; addr = 8'h20; drv = 16'hFFFF;
        @(negedge clk);
        chk("wd_wait_busy", {31'h0, busy}, 32'd1);
        chk("wd_wait_abort", {31'h0, abort}, 32'd0);
        #1; enable = 1'b0; ctrl = 2'b00; drv = 16'h5A5A;
        @(negedge clk);
        chk("wd_abort", {31'h0, abort}, 32'd1);
        chk("wd_busy", {31'h0, busy}, 32'd0);
        chk("wd_ready", {31'h0, ready}, 32'd0);
        #1;
        @(negedge clk);
        chk("wd_abort_end", {31'h0, abort}, 32'd0);
        #1;
        xfer(1'b0, 8'h20, 16'h0000, WS + 2);

        // read switching to write during wait
        enable = 1'b1; ctrl = 2'b01; addr = 8'h12; drv = 16'h0000;
        @(negedge clk);
        #1; ctrl = 2'b11;
        @(negedge clk);
        chk("sw_abort", {31'h0, abort}, 32'd1);
        chk("sw_busy", {31'h0, busy}, 32'd0);
        #1; enable = 1'b0; ctrl = 2'b00; drv = 16'h5A5A;
        @(negedge clk);
        chk("sw_idle", {31'h0, busy}, 32'd0);
        #1;
        xfer(1'b0, 8'h12, 16'h0000, WS + 2);

        // long hold gives exactly one write
        xfer(1'b1, 8'h30, 16'hC0DE, 10);
        xfer(1'b0, 8'h30, 16'h0000, WS + 2);

        // write request dropped in the data phase
        xfer(1'b1, 8'h50, 16'h5555, WS + 2);
        enable = 1'b1; ctrl = 2'b11; addr = 8'h50; drv = 16'h9999;
        for (int c = 1; c <= WS + 1; c++) begin
            @(negedge clk);
            #1;
        end
        enable = 1'b0; ctrl = 2'b00;
        @(negedge clk);
        chk("wdd_abort", {31'h0, abort}, 32'd1);
        chk("wdd_busy", {31'h0, busy}, 32'd0);
        chk("wdd_ready", {31'h0, ready}, 32'd0);
        #1; drv = 16'h5A5A;
        xfer(1'b0, 8'h50, 16'h0000, WS + 2);

        // reset in RD_WAIT, then in RD_DATA; first request right at release
        rd_reset(1);
        clr_n = 1'b1;
        xfer(1'b0, 8'h12, 16'h0000, WS + 2);
        rd_reset(WS + 1);
        clr_n = 1'b1;
        xfer(1'b0, 8'h12, 16'h0000, WS + 2);

        // reset during WR_DATA must not write
        xfer(1'b1, 8'h40, 16'h4444, WS + 2);
        enable = 1'b1; ctrl = 2'b11; addr = 8'h40; drv = 16'h7777;
        for (int c = 1; c <= WS + 1; c++) begin
            @(negedge clk);
            #1;
        end
        clr_n = 1'b0;
        #1;
        chk("wrst_busy", {31'h0, busy}, 32'd0);
        chk("wrst_ready", {31'h0, ready}, 32'd0);
        @(negedge clk);
        #1;
        enable = 1'b0; ctrl = 2'b00; drv = 16'h5A5A; clr_n = 1'b1;
        xfer(1'b0, 8'h40, 16'h0000, WS + 2);

        // zero wait states
        enable1 = 1'b1; ctrl1 = 2'b11; addr1 = 8'h05; drv1 = 16'hA5A5;
        @(negedge clk);
        chk("ws0_wr_ready", {31'h0, ready1}, 32'd1);
        #1;
        @(negedge clk);
        chk("ws0_wr_done", {31'h0, ready1}, 32'd0);
        #1; enable1 = 1'b0; ctrl1 = 2'b00; drv1 = 16'h5A5A;
        @(negedge clk);
        chk("ws0_wr_idle", {31'h0, busy1}, 32'd0);
        #1; enable1 = 1'b1; ctrl1 = 2'b01; addr1 = 8'h05; oe1 = 1'b0;
        @(negedge clk);
        chk("ws0_rd_ready", {31'h0, ready1}, 32'd1);
        chk("ws0_rd_data", {16'h0, ramio1}, 32'hA5A5);
        #1; oe1 = 1'b1;
        @(negedge clk);
        chk("ws0_rd_done", {31'h0, ready1}, 32'd0);
        #1; enable1 = 1'b0; ctrl1 = 2'b00;
        @(negedge clk);
        chk("ws0_rd_idle", {31'h0, busy1}, 32'd0);
        #1;

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
